// File: rtl/sccb_pkg.sv
// sccb_pkg: shared FSM state enum, device ID, register addresses/defaults for the SCCB target.
package sccb_pkg;
  localparam logic [7:0] SCCB_DEV_ID   = 8'h42;
  localparam logic [7:0] PID_ADDR      = 8'h0A;
  localparam logic [7:0] PID_VAL       = 8'h76;
  localparam logic [7:0] VER_ADDR      = 8'h0B;
  localparam logic [7:0] VER_VAL       = 8'h73;
  localparam logic [7:0] SOFT_RST_ADDR = 8'h12;
  typedef enum logic [3:0] {
    ST_IDLE, ST_ID, ST_ID_ACK, ST_SUB, ST_SUB_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RD_NA, ST_WAIT_STOP
  } sccb_state_e;
  function automatic logic [7:0] reg_default(input logic [7:0] a);
    return a == PID_ADDR ? PID_VAL : a == VER_ADDR ? VER_VAL : 8'h00;
  endfunction
endpackage

// File: rtl/sccb_sync_edge.sv
// sccb_sync_edge: 2-flop synchronizer with rise/fall detect on the synchronized value.
module sccb_sync_edge (
  input  logic clk,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  // Left unreset so a reset mid-transaction never fabricates a bus edge.
  logic [2:0] sync_q;
  always_ff @(posedge clk) sync_q <= {sync_q[1:0], d};
  assign q    = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB register target with 256x8 register file; define SCCB_TARGET_ACK_EN to drive
// SIO_D low during the 9th bit of ID/sub-address/write-data bytes.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID = SCCB_DEV_ID
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       SIO_C,
  inout  wire        SIO_D,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
`ifdef SCCB_TARGET_ACK_EN
  localparam logic ACK_DRIVE = 1'b1;
`else
  localparam logic ACK_DRIVE = 1'b0;
`endif
  localparam logic [7:0] RD_ID = DEV_ID | 8'h01;
  sccb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d, sub_q, sub_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic       oe_q, oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [7:0] mem_q [256];
  logic scl_s, scl_rise, scl_fall, sda_s, sda_rise, sda_fall;
  logic start, stop, data_st, ack_st, id_ok, rd_go, soft_rst;
  sccb_sync_edge u_scl (.clk(PCLK), .d(SIO_C), .q(scl_s), .rise(scl_rise), .fall(scl_fall));
  sccb_sync_edge u_sda (.clk(PCLK), .d(SIO_D), .q(sda_s), .rise(sda_rise), .fall(sda_fall));
  assign start    = sda_fall & scl_s;
  assign stop     = sda_rise & scl_s;
  assign data_st  = state_q inside {ST_ID, ST_SUB, ST_WDATA};
  assign ack_st   = state_q inside {ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK, ST_RD_NA};
  assign id_ok    = shift_q == DEV_ID || shift_q == RD_ID;
  assign rd_go    = state_q == ST_ID_ACK && shift_q == RD_ID;
  assign soft_rst = wr_strobe_q && wr_addr_q == SOFT_RST_ADDR && wr_data_q[7];
  // Bits are counted 1..9 on SIO_C rises; state moves and drive changes happen on the following fall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    sub_d       = sub_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (start) begin
      state_d = ST_ID;
      cnt_d   = '0;
      busy_d  = 1'b1;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (state_q != ST_IDLE && state_q != ST_WAIT_STOP) begin
      if (scl_rise) begin
        cnt_d = cnt_q + 4'd1;
        if (data_st) shift_d = {shift_q[6:0], sda_s};
        if (state_q == ST_WDATA && cnt_q == 4'd7) begin
          wr_strobe_d = 1'b1;
          wr_addr_d   = sub_q;
          wr_data_d   = {shift_q[6:0], sda_s};
        end
      end else if (scl_fall) begin
        if (data_st && cnt_q == 4'd8) begin
          state_d = state_q == ST_ID ? (id_ok ? ST_ID_ACK : ST_WAIT_STOP)
                  : state_q == ST_SUB ? ST_SUB_ACK : ST_WDATA_ACK;
          oe_d    = ACK_DRIVE && (state_q != ST_ID || id_ok);
          tx_d    = '0;
          if (state_q == ST_SUB) sub_d = shift_q;
        end else if (ack_st && cnt_q == 4'd9) begin
          cnt_d   = '0;
          state_d = rd_go ? ST_RDATA : state_q == ST_ID_ACK ? ST_SUB
                  : state_q == ST_SUB_ACK ? ST_WDATA : ST_WAIT_STOP;
          oe_d    = rd_go;
          tx_d    = mem_q[sub_q];
        end else if (state_q == ST_RDATA) begin
          state_d = cnt_q == 4'd8 ? ST_RD_NA : ST_RDATA;
          oe_d    = cnt_q != 4'd8;
          tx_d    = {tx_q[6:0], 1'b0};
        end
      end
    end
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      sub_q       <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      sub_q       <= sub_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end
  // Soft reset reloads defaults on the edge closing the wr_strobe cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET || soft_rst)
      for (int i = 0; i < 256; i++) mem_q[i] <= reg_default(8'(i));
    else if (wr_strobe_d)
      mem_q[wr_addr_d] <= wr_data_d;
  end
  assign SIO_D     = oe_q ? tx_q[7] : 1'bz;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed + randomized SCCB transactions checked against a register-level model.
module tb_sccb_target;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
  wire sda;
  logic wr_strobe, busy;
  logic [7:0] wr_addr, wr_data;
  int n_cmp = 0, n_err = 0, n_strobe = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] ref_sub;
  logic exp_ack;
  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  sccb_target #(.DEV_ID(8'h42)) dut (
    .PCLK(clk), .PRESET(rst), .SIO_C(scl), .SIO_D(sda),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );
  always @(negedge clk) if (wr_strobe) n_strobe++;
  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic ref_defaults();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[8'h0A] = 8'h76;
    ref_mem[8'h0B] = 8'h73;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic bit_io(input logic drv, output logic smp);
    tick(4); m_low = !drv; tick(4); scl = 1'b1; tick(4); #1 smp = sda; tick(4); scl = 1'b0;
  endtask
  task automatic start_c();
    tick(4); m_low = 1'b0; tick(4); scl = 1'b1; tick(4); m_low = 1'b1; tick(4); scl = 1'b0;
  endtask
  task automatic stop_c();
    tick(4); m_low = 1'b1; tick(4); scl = 1'b1; tick(4); m_low = 1'b0; tick(8);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic [7:0] echo, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin bit_io(b[i], s); echo[i] = s; end
    bit_io(1'b1, ack);
  endtask
  task automatic recv_byte(output logic [7:0] b, output logic na);
    logic s;
    for (int i = 7; i >= 0; i--) begin bit_io(1'b1, s); b[i] = s; end
    bit_io(1'b1, na);
  endtask
  task automatic do_write(input string tag, input logic [7:0] id, input logic [7:0] sub,
                          input logic [7:0] data, input bit three);
    logic [7:0] e;
    logic a;
    bit hit;
    int s0;
    hit = id == 8'h42;
    s0 = n_strobe;
    start_c();
    send_byte(id, e, a);
    chk({tag, "_id_echo"}, 16'(e), 16'(id));
    chk({tag, "_id_ack"}, 16'(a), 16'(hit ? exp_ack : 1'b1));
    chk({tag, "_busy"}, 16'(busy), 16'd1);
    send_byte(sub, e, a);
    chk({tag, "_sub_echo"}, 16'(e), 16'(sub));
    chk({tag, "_sub_ack"}, 16'(a), 16'(hit ? exp_ack : 1'b1));
    if (three) begin
      send_byte(data, e, a);
      chk({tag, "_dat_echo"}, 16'(e), 16'(data));
      chk({tag, "_dat_ack"}, 16'(a), 16'(hit ? exp_ack : 1'b1));
    end
    stop_c();
    chk({tag, "_busy_clr"}, 16'(busy), 16'd0);
    chk({tag, "_strobes"}, 16'(n_strobe - s0), 16'((hit && three) ? 1 : 0));
    if (hit) begin
      ref_sub = sub;
      if (three) begin
        chk({tag, "_wr_addr"}, 16'(wr_addr), 16'(sub));
        chk({tag, "_wr_data"}, 16'(wr_data), 16'(data));
        ref_mem[sub] = data;
        if (sub == 8'h12 && data[7]) ref_defaults();
      end
    end
  endtask
  task automatic do_read(input string tag);
    logic [7:0] e, b;
    logic a, na;
    start_c();
    send_byte(8'h43, e, a);
    chk({tag, "_rid_ack"}, 16'(a), 16'(exp_ack));
    recv_byte(b, na);
    chk({tag, "_rdata"}, 16'(b), 16'(ref_mem[ref_sub]));
    chk({tag, "_na_released"}, 16'(na), 16'd1);
    stop_c();
    chk({tag, "_rd_busy_clr"}, 16'(busy), 16'd0);
  endtask
  initial begin
    logic [7:0] e, d, id;
    logic a, s;
    int s0;
`ifdef SCCB_TARGET_ACK_EN
    exp_ack = 1'b0;
`else
    exp_ack = 1'b1;
`endif
    ref_defaults();
    ref_sub = 8'h00;
    tick(6);
    #1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_strobe", 16'(wr_strobe), 16'd0);
    chk("rst_addr", 16'(wr_addr), 16'd0);
    chk("rst_data", 16'(wr_data), 16'd0);
    chk("rst_sda", 16'(sda), 16'd1);
    rst = 1'b0;
    tick(4);
    do_read("rd_after_rst");
    do_write("w3", 8'h42, 8'h3A, 8'h55, 1'b1);
    do_write("w2_pid", 8'h42, 8'h0A, 8'h00, 1'b0);
    do_read("rd_pid");
    do_write("bad_id", 8'h60, 8'h3A, 8'h11, 1'b1);
    do_write("w2_3a", 8'h42, 8'h3A, 8'h00, 1'b0);
    do_read("rd_3a_kept");
    do_write("w3_3a", 8'h42, 8'h3A, 8'h55, 1'b1);
    do_write("soft_rst", 8'h42, 8'h12, 8'h80, 1'b1);
    do_write("w2_3a_b", 8'h42, 8'h3A, 8'h00, 1'b0);
    do_read("rd_3a_soft");
    do_write("w2_ver", 8'h42, 8'h0B, 8'h00, 1'b0);
    do_read("rd_ver_soft");
    do_write("w2_12", 8'h42, 8'h12, 8'h00, 1'b0);
    do_read("rd_12_soft");
    s0 = n_strobe;
    start_c();
    send_byte(8'h42, e, a);
    send_byte(8'h3A, e, a);
    d = 8'($urandom);
    for (int i = 7; i >= 4; i--) bit_io(d[i], s);
    do_write("rstart", 8'h42, 8'h3A, 8'hA5, 1'b1);
    chk("rstart_total_strobes", 16'(n_strobe - s0), 16'd1);
    s0 = n_strobe;
    start_c();
    send_byte(8'h42, e, a);
    send_byte(8'h3A, e, a);
    d = 8'($urandom);
    for (int i = 7; i >= 5; i--) bit_io(d[i], s);
    stop_c();
    chk("midstop_strobes", 16'(n_strobe - s0), 16'd0);
    do_read("rd_after_midstop");
    for (int k = 0; k < 8; k++) begin
      id = ($urandom_range(0, 3) != 0) ? 8'h42 : 8'($urandom);
      if (id != 8'h42 && id[7:1] == 7'h21) id = 8'h60;
      do_write("rnd_w", id, 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
      do_read("rnd_r");
    end
    d = 8'(($urandom & 32'hEE) | 32'h01);
    do_write("w_pid_d", 8'h42, 8'h0A, d, 1'b1);
    start_c();
    send_byte(8'h43, e, a);
    for (int i = 0; i < 3; i++) bit_io(1'b1, s);
    tick(6);
    #1 chk("rd_bit3_driven", 16'(sda), 16'(d[4]));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_sda", 16'(sda), 16'd1);
    chk("rst_mid_busy", 16'(busy), 16'd0);
    tick(2);
    rst = 1'b0;
    #1;
    chk("rst_mid_addr", 16'(wr_addr), 16'd0);
    chk("rst_mid_data", 16'(wr_data), 16'd0);
    ref_defaults();
    ref_sub = 8'h00;
    stop_c();
    do_read("rd_sub_after_rst");
    do_write("w2_pid_b", 8'h42, 8'h0A, 8'h00, 1'b0);
    do_read("rd_pid_after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sccb_target.md
SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 The block SHALL have parameter DEV_ID, default 8'h42, meaning 8-bit write ID; read ID is DEV_ID|1.
REQ-002 The block SHALL have port PCLK  input  1  system clock, at least 16x SIO_C frequency.
REQ-003 The block SHALL have port PRESET  input  1  reset, synchronous to PCLK, active-high.
REQ-004 The block SHALL have port SIO_C  input  1  SCCB clock from master, asynchronous.
REQ-005 The block SHALL have port SIO_D  inout  1  SCCB data, high-Z unless driving.
REQ-006 The block SHALL have port wr_strobe  output  1  one-cycle pulse per accepted register write.
REQ-007 The block SHALL have port wr_addr  output  8  sub-address of the last accepted write.
REQ-008 The block SHALL have port wr_data  output  8  data of the last accepted write.
REQ-009 The block SHALL have port busy  output  1  high from START to STOP.

Function
REQ-010 The block SHALL pass SIO_C and SIO_D through 2-flop synchronizers and detect edges on the synchronized values.
REQ-011 START SHALL be SIO_D falling while SIO_C high; in any state it SHALL go to ID (repeated start) and set busy.
REQ-012 STOP SHALL be SIO_D rising while SIO_C high; in any state it SHALL go to IDLE, clear busy and release SIO_D.
REQ-013 The block SHALL sample bits MSB first on SIO_C rising edges and SHALL change driven data only after SIO_C falling edges.
REQ-014 The FSM states SHALL be IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, WAIT_STOP.
REQ-015 If the ID byte equals DEV_ID, the FSM SHALL go ID_ACK->SUB->SUB_ACK->WDATA->WDATA_ACK.
REQ-016 If the ID byte equals DEV_ID|1, the FSM SHALL go ID_ACK->RDATA.
REQ-017 Any other ID SHALL go to WAIT_STOP; the block SHALL never drive SIO_D and SHALL not strobe until the next START or STOP.
REQ-018 The sub-address SHALL be latched at the end of SUB and SHALL persist across transactions; a 2-phase write (ID, SUB, STOP) SHALL only set it.
REQ-019 A 256x8 register file SHALL hold all registers; defaults are 0x0A=0x76, 0x0B=0x73, all others 0x00.
REQ-020 On the 8th WDATA bit, the block SHALL write the register file, update wr_addr/wr_data and pulse wr_strobe exactly one PCLK cycle later.
REQ-021 In RDATA, the block SHALL drive reg[sub-address] push-pull MSB first over 8 bits; there is no auto-increment.
REQ-022 In RD_NA, the block SHALL release SIO_D, ignore the NA bit value, then go to WAIT_STOP.
REQ-023 After WDATA_ACK, the FSM SHALL go to WAIT_STOP; extra bytes SHALL be ignored.
REQ-024 A write of a value with bit 7 set to sub-address 0x12 SHALL restore all register defaults in the cycle after wr_strobe; reg 0x12 SHALL then read 0x00.
REQ-025 A START or STOP mid-byte SHALL discard the partial byte with no wr_strobe and no register-file change.

Reset
REQ-026 While PRESET is high at a PCLK edge, the FSM SHALL be IDLE, busy=0, wr_strobe=0, wr_addr=0, wr_data=0 and SIO_D released.
REQ-027 Reset SHALL reload register defaults and sub-address 0x00.
REQ-028 Reset mid-transaction SHALL release SIO_D in the following cycle; the bus SHALL be ignored until the next START.

Configuration
REQ-029 The block SHALL support macro SCCB_TARGET_ACK_EN.
REQ-030 With SCCB_TARGET_ACK_EN defined, the block SHALL drive SIO_D low for the full 9th bit in ID_ACK, SUB_ACK and WDATA_ACK.
REQ-031 Without SCCB_TARGET_ACK_EN, SIO_D SHALL stay high-Z in the 9th bit (SCCB don't-care bit); the FSM timing SHALL be unchanged.

Structure
REQ-032 Package sccb_pkg SHALL hold the FSM state enum, the default ID 8'h42, the PID/VER addresses and values, and the soft-reset address 0x12.
REQ-033 The design SHALL have one sub-module, sccb_sync_edge: synchronizer plus rise/fall detect, instantiated for SIO_C and SIO_D.

Verification
REQ-034 Test: 3-phase write ID 0x42, sub 0x3A, data 0x55 -> one wr_strobe with wr_addr=0x3A and wr_data=0x55, SIO_D low in each 9th bit with ACK_EN.
REQ-035 Test: 2-phase write ID 0x42, sub 0x0A, STOP, then ID 0x43 read -> 0x76 driven MSB first, SIO_D released at NA, busy cleared at STOP.
REQ-036 Test: ID 0x60, sub 0x3A, data 0x11 -> SIO_D never driven, no wr_strobe, later read of 0x3A returns prior value.
REQ-037 Test: write 0x3A=0x55, then write 0x12=0x80, then read 0x3A and 0x0B -> 0x00 and 0x73.
REQ-038 Test: repeated START after 4 bits of WDATA, then full write 0x3A=0xA5 -> exactly one wr_strobe with data 0xA5.
REQ-039 Test: PRESET asserted during RDATA bit 3 -> SIO_D high-Z next cycle, busy=0, sub-address 0x00, register file at defaults.
